// File: rtl/dm_bus_pkg.sv
// Shared types and constants for the data-memory bus responder.
// Holds the FSM state encoding, the byte-enable patterns and the wait-state limit.
package dm_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmState_t;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_B0    = 4'b0001;
  localparam logic [3:0] BE_B1    = 4'b0010;
  localparam logic [3:0] BE_B2    = 4'b0100;
  localparam logic [3:0] BE_B3    = 4'b1000;

  localparam int WAIT_CYCLES_MAX = 15;

  // True when any byte-address bit above the implemented word range is set.
  function automatic logic addrOutOfRange(logic [31:0] addr, int addrW);
    return (addr >> (addrW + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/dm_bus_responder_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
// A beat moves on a rising edge where valid and ready are both 1; valid, once raised,
// stays up with its payload stable until that edge, and ready never depends on a future beat.
interface dm_bus_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge: lanes with be set take wdata, the rest keep the old word.
module dm_byte_merge (
  input  logic [31:0] oldWord,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  always_comb begin
    merged = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_bus_responder.sv
// Valid/ready data-memory responder with programmable wait states and range checking.
// Optional store/error trace is compiled in with DM_RESPONDER_TRACE_EN.
module dm_bus_responder
  import dm_bus_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dm_bus_responder_if.slave    bus,
  output dmState_t             dbgState
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int WAIT_EFF = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
  localparam logic [3:0] CNT_LOAD = (WAIT_EFF > 0) ? 4'(WAIT_EFF - 1) : 4'd0;

  dmState_t    state, nextState;
  logic [3:0]  cnt;
  logic        weQ;
  logic [31:0] addrQ;
  logic [3:0]  beQ;
  logic [31:0] wdataQ;
  logic [31:0] rdataQ;
  logic        errQ;
  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              commitNow;
  logic              cmdWe;
  logic [31:0]       cmdAddr;
  logic [3:0]        cmdBe;
  logic [31:0]       cmdWdata;
  logic              outOfRange;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       merged;

  assign accept = (state == IDLE) && bus.req_valid;

  // With no wait states the commit happens on the acceptance edge, so it must use the live request.
  always_comb begin
    cmdWe    = weQ;
    cmdAddr  = addrQ;
    cmdBe    = beQ;
    cmdWdata = wdataQ;
    if (state == IDLE) begin
      cmdWe    = bus.req_we;
      cmdAddr  = bus.req_addr;
      cmdBe    = bus.req_be;
      cmdWdata = bus.req_wdata;
    end
  end

  assign commitNow  = (accept && (WAIT_EFF == 0)) || ((state == WAIT) && (cnt == 4'd0));
  assign outOfRange = addrOutOfRange(cmdAddr, ADDR_W);
  assign idx        = cmdAddr[ADDR_W+1:2];

  dm_byte_merge uMerge (
    .oldWord (mem[idx]),
    .wdata   (cmdWdata),
    .be      (cmdBe),
    .merged  (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (bus.req_valid) nextState = (WAIT_EFF == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0)   nextState = RESP;
      RESP: if (bus.rsp_ready) nextState = IDLE;
      default:                 nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE) && reset;
    bus.rsp_valid = (state == RESP);
    bus.rsp_rdata = rdataQ;
    bus.rsp_err   = errQ;
    dbgState      = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 4'd0;
      weQ    <= 1'b0;
      addrQ  <= 32'd0;
      beQ    <= 4'd0;
      wdataQ <= 32'd0;
      rdataQ <= 32'd0;
      errQ   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      if (accept) begin
        weQ    <= bus.req_we;
        addrQ  <= bus.req_addr;
        beQ    <= bus.req_be;
        wdataQ <= bus.req_wdata;
        cnt    <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commitNow) begin
        rdataQ <= 32'd0;
        errQ   <= outOfRange;
        if (!outOfRange) begin
          if (cmdWe) mem[idx] <= merged;
          else       rdataQ   <= mem[idx];
        end
      end
    end
  end

`ifdef DM_RESPONDER_TRACE_EN
  logic [31:0] pcQ;
  logic [31:0] cmdPc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      pcQ <= 32'd0;
    else if (accept) pcQ <= bus.req_pc;
  end

  assign cmdPc = (state == IDLE) ? bus.req_pc : pcQ;

  always_ff @(posedge clk) begin
    if (reset && commitNow) begin
      if (outOfRange)
        $display("%0t @%08h: DM ERR %08h", $time, cmdPc, cmdAddr);
      else if (cmdWe && (cmdBe != 4'd0))
        $display("%0t @%08h: *%08h <= %08h", $time, cmdPc, {cmdAddr[31:2], 2'b00}, merged);
    end
  end
`else
  logic unusedPc;
  assign unusedPc = ^bus.req_pc;
`endif

endmodule

// File: tb/tb_dm_bus_responder.sv
// Bench for dm_bus_responder: table vectors, corner sequences and random traffic on a
// one-wait-state instance and a zero-wait-state instance, checked against a memory model.
module tb_dm_bus_responder;
  import dm_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [1:0]  reqValid;
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [3:0]  reqBe;
  logic [31:0] reqWdata;
  logic [31:0] reqPc;
  logic        rspReady;

  dm_bus_responder_if bus0 ();
  dm_bus_responder_if bus1 ();

  assign bus0.req_valid = reqValid[0];
  assign bus0.req_we    = reqWe;
  assign bus0.req_addr  = reqAddr;
  assign bus0.req_be    = reqBe;
  assign bus0.req_wdata = reqWdata;
  assign bus0.req_pc    = reqPc;
  assign bus0.rsp_ready = rspReady;
  assign bus1.req_valid = reqValid[1];
  assign bus1.req_we    = reqWe;
  assign bus1.req_addr  = reqAddr;
  assign bus1.req_be    = reqBe;
  assign bus1.req_wdata = reqWdata;
  assign bus1.req_pc    = reqPc;
  assign bus1.rsp_ready = rspReady;

  dmState_t dbg0, dbg1;

  dm_bus_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .dbgState(dbg0)
  );
  dm_bus_responder #(.ADDR_W(12), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .dbgState(dbg1)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] refMem [2][4096];
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  function automatic void clearRef();
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 4096; w++) refMem[s][w] = 32'd0;
  endfunction

  // Memory of 4096 words; any byte address at or above 0x4000 is an error.
  function automatic void refStep(input int sel, input bit we, input logic [31:0] addr,
                                  input logic [3:0] be, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
    int word;
    rd = 32'd0;
    er = 1'b0;
    if (addr >= 32'h0000_4000) begin
      er = 1'b1;
    end else begin
      word = int'(addr / 4);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) refMem[sel][word][8*i +: 8] = wd[8*i +: 8];
      end else begin
        rd = refMem[sel][word];
      end
    end
  endfunction

  function automatic logic getReady(input int sel);
    return (sel == 1) ? bus1.req_ready : bus0.req_ready;
  endfunction
  function automatic logic getValid(input int sel);
    return (sel == 1) ? bus1.rsp_valid : bus0.rsp_valid;
  endfunction
  function automatic logic [31:0] getRdata(input int sel);
    return (sel == 1) ? bus1.rsp_rdata : bus0.rsp_rdata;
  endfunction
  function automatic logic getErr(input int sel);
    return (sel == 1) ? bus1.rsp_err : bus0.rsp_err;
  endfunction

  // ---------------- driver ----------------
  // Entered and left at posedge+1; hold = cycles the response is stalled before consuming.
  task automatic txn(input int sel, input bit we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input int hold, input bit preReady,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    rd  = 32'd0;
    er  = 1'b0;
    lat = 0;
    reqWe = we; reqAddr = addr; reqBe = be; reqWdata = wdata; reqPc = $urandom;
    reqValid[sel] = 1'b1;
    rspReady = preReady;
    n = 0;
    do begin @(negedge clk); n++; end while (!getReady(sel) && n < 20);
    if (!getReady(sel)) begin
      check("accept_timeout", 32'd0, 32'd1);
      reqValid[sel] = 1'b0;
      rspReady = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    reqValid[sel] = 1'b0;
    reqWe = 1'($urandom); reqAddr = $urandom; reqBe = 4'($urandom); reqWdata = $urandom;
    do begin
      @(negedge clk);
      lat++;
      check("busy_req_ready", {31'd0, getReady(sel)}, 32'd0);
    end while (!getValid(sel) && lat < 40);
    if (!getValid(sel)) begin
      check("rsp_timeout", 32'd0, 32'd1);
      rspReady = 1'b0;
      @(posedge clk); #1;
      return;
    end
    rd = getRdata(sel);
    er = getErr(sel);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, getValid(sel)}, 32'd1);
      check("hold_rdata", getRdata(sel), rd);
      check("hold_err", {31'd0, getErr(sel)}, {31'd0, er});
      check("hold_req_ready", {31'd0, getReady(sel)}, 32'd0);
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] expRd;
    logic        expErr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat;

    vecs[0]  = '{1'b1, 32'h0000_0010, BE_WORD,  32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, BE_WORD,  32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0011, BE_B1,    32'h0000_AB00, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, BE_WORD,  32'h0000_0000, 32'h1234_AB78, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_4000, BE_WORD,  32'h55AA_55AA, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0000, BE_WORD,  32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_4000, BE_WORD,  32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 32'h0000_0012, 4'b0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0013, 4'b0000,  32'h0000_0000, 32'h1234_AB78, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0014, BE_HALF1, 32'hBEEF_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0014, BE_WORD,  32'h0000_0000, 32'hBEEF_0000, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_3FFC, BE_WORD,  32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_3FFC, BE_HALF0, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    vecs[13] = '{1'b0, 32'h8000_0000, BE_WORD,  32'h0000_0000, 32'h0000_0000, 1'b1};

    reset = 1'b0; reqValid = 2'b00; reqWe = 1'b0; reqAddr = 32'd0; reqBe = 4'd0;
    reqWdata = 32'd0; reqPc = 32'd0; rspReady = 1'b0;
    clearRef();

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_req_ready1", {31'd0, bus1.req_ready}, 32'd0);
    check("rst_req_ready0", {31'd0, bus0.req_ready}, 32'd0);
    check("rst_rsp_valid1", {31'd0, bus1.rsp_valid}, 32'd0);
    check("rst_rdata1", bus1.rsp_rdata, 32'd0);
    check("rst_err1", {31'd0, bus1.rsp_err}, 32'd0);
    check("rst_state0", {30'd0, dbg0}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_req_ready1", {31'd0, bus1.req_ready}, 32'd1);
    @(posedge clk); #1;

    // Table vectors on the one-wait-state instance.
    for (int i = 0; i < 14; i++) begin
      txn(1, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, 0, 1'b0, rd, er, lat);
      refStep(1, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, mrd, mer);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
      check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].expErr});
      check($sformatf("vec%0d_latency", i), lat, 32'd2);
    end

    // Stalled response: outputs hold for 5 cycles, then the responder frees up.
    txn(1, 1'b0, 32'h0000_0010, BE_WORD, 32'd0, 5, 1'b0, rd, er, lat);
    refStep(1, 1'b0, 32'h0000_0010, BE_WORD, 32'd0, mrd, mer);
    check("stall_rdata", rd, 32'h1234_AB78);
    @(negedge clk);
    check("stall_release_ready", {31'd0, bus1.req_ready}, 32'd1);
    check("stall_release_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    @(posedge clk); #1;

    // Zero wait states: response the cycle after acceptance.
    txn(0, 1'b1, 32'h0000_0008, BE_WORD, 32'hCAFE_F00D, 0, 1'b0, rd, er, lat);
    refStep(0, 1'b1, 32'h0000_0008, BE_WORD, 32'hCAFE_F00D, mrd, mer);
    check("w0_store_latency", lat, 32'd1);
    txn(0, 1'b0, 32'h0000_0008, BE_WORD, 32'd0, 0, 1'b0, rd, er, lat);
    refStep(0, 1'b0, 32'h0000_0008, BE_WORD, 32'd0, mrd, mer);
    check("w0_load_rdata", rd, 32'hCAFE_F00D);
    check("w0_load_latency", lat, 32'd1);

    // Reset asserted while a store waits: it must never commit.
    reqWe = 1'b1; reqAddr = 32'h0000_0020; reqBe = BE_WORD; reqWdata = 32'hDEAD_BEEF;
    reqValid[1] = 1'b1;
    @(negedge clk);
    check("rstwait_accept", {31'd0, bus1.req_ready}, 32'd1);
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    reset = 1'b0;
    clearRef();
    #1;
    check("rstwait_ready", {31'd0, bus1.req_ready}, 32'd0);
    check("rstwait_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    check("rstwait_rdata", bus1.rsp_rdata, 32'd0);
    check("rstwait_err", {31'd0, bus1.rsp_err}, 32'd0);
    check("rstwait_state", {30'd0, dbg1}, 32'd0);
    repeat (2) @(negedge clk);
    check("rstwait_ready_held", {31'd0, bus1.req_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    txn(1, 1'b0, 32'h0000_0020, BE_WORD, 32'd0, 0, 1'b0, rd, er, lat);
    check("rstwait_load20", rd, 32'd0);
    txn(1, 1'b0, 32'h0000_0010, BE_WORD, 32'd0, 0, 1'b0, rd, er, lat);
    check("rstwait_load10", rd, 32'd0);

    // Random traffic on both instances against the model.
    for (int n = 0; n < 160; n++) begin
      int sel, hold;
      bit we, pre;
      logic [31:0] addr, wd;
      logic [3:0] be;
      logic [32:0] exp;
      sel  = $urandom_range(0, 1);
      we   = 1'($urandom_range(0, 1));
      be   = 4'($urandom);
      wd   = $urandom;
      addr = ($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = addr | (32'($urandom_range(1, 16'hFFFF)) << 14);
      if ($urandom_range(0, 15) == 0) addr = 32'h0000_3FFC | 32'($urandom_range(0, 3));
      pre  = 1'($urandom_range(0, 1));
      hold = pre ? 0 : $urandom_range(0, 3);
      refStep(sel, we, addr, be, wd, mrd, mer);
      exp_q.push_back({mer, mrd});
      txn(sel, we, addr, be, wd, hold, pre, rd, er, lat);
      exp = exp_q.pop_front();
      check($sformatf("rnd%0d_rdata", n), rd, exp[31:0]);
      check($sformatf("rnd%0d_err", n), {31'd0, er}, {31'd0, exp[32]});
      check($sformatf("rnd%0d_latency", n), lat, (sel == 1) ? 32'd2 : 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
